// File: rtl/parity_check_scheduler.sv
// Shared 4-bit even-parity checker with round-robin arbitration among
// N_REQ requesters, a valid/ack result handshake and a saturating error count.

// Combinational even-parity checker: C = X ^ Y ^ Z ^ P.
module even_parity_checker (
    input  logic [3:0] word,
    output logic       c
);
    assign c = ^word;
endmodule

module parity_check_scheduler #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [4*N_REQ-1:0]   data,
    output logic [N_REQ-1:0]     gnt,
    output logic                 res_valid,
    output logic [ID_W-1:0]      res_id,
    output logic                 res_err,
    input  logic                 res_ack,
    input  logic                 clr_count,
    output logic [CNT_W-1:0]     err_count,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] id_q;
    logic [3:0]      word_q;

    logic            found;
    logic [ID_W-1:0] winner;
    logic [3:0]      win_word;
    logic [ID_W:0]   scan_sum;
    logic [ID_W-1:0] scan_idx;
    logic            chk_c;
    logic [ID_W-1:0] next_ptr;

    // Round-robin scan: first requester with req set, starting at rr_ptr and wrapping.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
        found    = 1'b0;
        winner   = '0;
        win_word = '0;
        scan_sum = '0;
        scan_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (scan_sum >= (ID_W+1)'(N_REQ))
                scan_sum = scan_sum - (ID_W+1)'(N_REQ);
            scan_idx = scan_sum[ID_W-1:0];
            if (!found && req[scan_idx]) begin
                found    = 1'b1;
                winner   = scan_idx;
                win_word = data[{scan_idx, 2'b00} +: 4];
            end
        end
    end

    // Pointer for the next arbitration round: requester after the one just served.
    always_comb begin
        if (id_q == ID_W'(N_REQ - 1))
            next_ptr = '0;
        else
            next_ptr = id_q + 1'b1;
    end

    even_parity_checker u_checker (
        .word (word_q),
        .c    (chk_c)
    );

    // Scheduler FSM: grant, check, then hold the result until acknowledged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            id_q      <= '0;
            word_q    <= '0;
            gnt       <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (found) begin
                        word_q <= win_word;
                        id_q   <= winner;
                        gnt    <= N_REQ'(1) << winner;
                        busy   <= 1'b1;
                        state  <= CHECK;
                    end
                end
                CHECK: begin
                    gnt       <= '0;
                    res_err   <= chk_c;
                    res_id    <= id_q;
                    res_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (res_ack) begin
                        res_valid <= 1'b0;
                        rr_ptr    <= next_ptr;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    gnt       <= '0;
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Saturating parity-error counter; a clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (clr_count) begin
            err_count <= '0;
        end else if (state == CHECK && chk_c && err_count != {CNT_W{1'b1}}) begin
            err_count <= err_count + 1'b1;
        end
    end

endmodule
